// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant plus index, rotating priority,
// tenure ends on release, requester withdrawal or a MAX_HOLD timeout.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       done_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       gnt_valid_o,
  output logic                       timeout_o
);

  localparam int unsigned IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned HOLD_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IDX_W-1:0]   idx_d;
  logic               valid_d, timeout_d;

  logic [IDX_W-1:0]   win_m, win_a, win_idx;
  logic               found_m, found_a;
  logic               released, hit_hold;

  // First requester at or above ptr, else lowest requester overall (wrap).
  always_comb begin
    win_m   = '0;
    win_a   = '0;
    found_m = 1'b0;
    found_a = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_i[i] && !found_a) begin
        win_a   = IDX_W'(i);
        found_a = 1'b1;
      end
      if (req_i[i] && !found_m && (IDX_W'(i) >= ptr_q)) begin
        win_m   = IDX_W'(i);
        found_m = 1'b1;
      end
    end
    win_idx = found_m ? win_m : win_a;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_o;
    idx_d     = gnt_idx_o;
    valid_d   = gnt_valid_o;
    timeout_d = 1'b0;
    released  = done_i || !req_i[gnt_idx_o];
    hit_hold  = (MAX_HOLD != 0) && (hold_q == HOLD_W'(HOLD_LAST));

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (released || hit_hold) begin
          state_d   = IDLE;
          gnt_d     = '0;
          idx_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
          // A simultaneous release or withdrawal counts as a normal release.
          timeout_d = !released;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_o       <= gnt_d;
      gnt_idx_o   <= idx_d;
      gnt_valid_o <= valid_d;
      timeout_o   <= timeout_d;
    end
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one downstream resource between NUM_REQ requesters and issues a registered one-hot grant plus its binary index. It sits in front of shared datapath blocks such as the priority encoder: requesters raise req_i, the winner owns the resource until it releases or a hold timeout expires, and priority then rotates past the last winner. It provides starvation-free sharing with a bounded tenure per grant.

## Interface
- NUM_REQ, 8, number of requesters (>= 2)
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; 0 disables the timeout
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived localparam, not overridable)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_i  in  NUM_REQ  request vector, bit k = requester k; level-sensitive
- done_i  in  1  current owner releases the grant; sampled only while gnt_valid_o=1
- gnt_o  out  NUM_REQ  one-hot grant, registered; all zero when idle
- gnt_idx_o  out  IDX_W  binary index of the granted requester, registered; 0 when idle
- gnt_valid_o  out  1  a grant is active, registered
- timeout_o  out  1  one-cycle pulse: current grant was revoked by MAX_HOLD

## Operation
- FSM with two states: IDLE and GRANT; reset state IDLE.
- Rotating pointer ptr (IDX_W bits), reset 0: the requester index with highest priority.
- Arbitration in IDLE: search req_i upward from ptr, wrapping at NUM_REQ-1 -> 0. The first set bit wins. Equivalent form: masked = req_i & (bits >= ptr); if masked != 0, take the lowest set bit of masked, else the lowest set bit of req_i.
- IDLE -> GRANT when req_i != 0: register gnt_o, gnt_idx_o, gnt_valid_o=1, and clear the hold counter.
- In GRANT, the tenure ends at an edge where any of these holds:
  - (a) done_i=1
  - (b) req_i[gnt_idx_o]=0 (requester withdrew)
  - (c) MAX_HOLD!=0 and hold count == MAX_HOLD-1
- At tenure end: go to IDLE, clear outputs, set ptr = (gnt_idx_o+1) mod NUM_REQ.
- If the tenure ends by (c) only, with neither (a) nor (b), timeout_o=1 in the following cycle.
- Hold counter: $clog2(MAX_HOLD+1) bits, increments each GRANT cycle, saturates, and clears on entry to GRANT.
- Requests changing while in GRANT do not alter the current grant.
- Fairness: with all NUM_REQ requesting continuously, grants are issued in strictly ascending index order with wrap. Any requester waits at most NUM_REQ-1 tenures.

## Timing
- Reset (async assert; deassert is synchronous to clk in the system): gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0, ptr=0, state IDLE.
- Grant latency: req_i sampled at edge N in IDLE -> gnt_o valid after edge N (visible in cycle N+1).
- Release: done_i high at edge M -> gnt_valid_o low after edge M. The earliest next grant is after edge M+1, giving exactly one idle cycle between tenures.
- Timeout: with MAX_HOLD=H, gnt_valid_o is high for exactly H cycles. timeout_o is high for the one cycle after the revoke edge.
- Simultaneous done_i and timeout at the same edge: normal release, timeout_o stays 0.
- Revoked requester still asserting req_i: it competes normally, and ptr has already moved past it.
- Reset mid-grant: outputs clear immediately (asynchronous) and ptr returns to 0.
- Outputs are pure flops; there is no combinational path from req_i or done_i to any output.

## Test plan
All scenarios use NUM_REQ=8 and MAX_HOLD=4.
- Reset: assert rst mid-grant -> gnt_o=0, gnt_valid_o=0, timeout_o=0 immediately. After release, req_i=8'b1000_0001 -> gnt_idx_o=0.
- Single request: req_i=8'b0000_1000 -> one cycle later gnt_o=8'b0000_1000, gnt_idx_o=3, gnt_valid_o=1. Pulse done_i -> gnt_valid_o=0 next cycle.
- Rotation: req_i=8'hFF held, done_i pulsed on every grant -> gnt_idx_o sequence 0,1,2,…,7,0 with one idle cycle between grants.
- Wrap/masking: after a grant to index 6 is released, req_i=8'b0100_0010 -> gnt_idx_o=1 (search wraps from ptr=7). Then with req_i held, the next grant is gnt_idx_o=6.
- Timeout: req_i=8'b0000_0100 held, done_i=0 -> gnt_valid_o high exactly 4 cycles, then timeout_o=1 for 1 cycle, then the grant is re-issued to index 2 after the idle cycle.
- Withdrawal and tie: owner 5 drops req_i[5] -> grant ends next edge with timeout_o=0. Separately, done_i and the timeout on the same edge -> timeout_o stays 0.
